// File: rtl/sensor_tx_scheduler.sv
// rtl/sensor_tx_scheduler.sv - round-robin framing scheduler sharing one 40-bit UART TX port
// between ADS1292 samples (three frames per packet) and MPR121 touch updates (one frame).
module sensor_tx_scheduler #(
  parameter logic [7:0] P_HDR_STAT  = 8'hE0,
  parameter logic [7:0] P_HDR_CH1   = 8'hE1,
  parameter logic [7:0] P_HDR_CH2   = 8'hE2,
  parameter logic [7:0] P_HDR_TOUCH = 8'h7C,
  parameter int         P_DROP_W    = 8
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_RUN,
  input  logic [71:0]         i_ADS_DATA,
  input  logic                i_ADS_VALID,
  input  logic [11:0]         i_TOUCH_STATUS,
  input  logic                i_TOUCH_VALID,
  output logic [39:0]         o_UART_DATA_TX,
  output logic                o_UART_DATA_TX_VALID,
  input  logic                i_UART_DATA_TX_READY,
  output logic [P_DROP_W-1:0] o_ADS_DROP_CNT,
  output logic                o_BUSY
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADS_STAT = 3'd1;
  localparam logic [2:0] S_ADS_CH1  = 3'd2;
  localparam logic [2:0] S_ADS_CH2  = 3'd3;
  localparam logic [2:0] S_TOUCH    = 3'd4;

  logic [2:0]          r_state;
  logic                r_ads_pend;
  logic                r_touch_pend;
  logic                r_rr_touch;
  logic [71:0]         r_ads_data;
  logic [11:0]         r_touch_data;
  logic [39:0]         r_tx_data;
  logic                r_tx_valid;
  logic [P_DROP_W-1:0] r_drop_cnt;

  logic        w_hs;
  logic        w_idle;
  logic        w_ads_cap;
  logic        w_ads_drop;
  logic        w_touch_cap;
  logic        w_grant_ads;
  logic        w_grant_touch;
  logic [39:0] w_frame_stat;
  logic [39:0] w_frame_ch1;
  logic [39:0] w_frame_ch2;
  logic [39:0] w_frame_touch;

  assign w_hs          = r_tx_valid & i_UART_DATA_TX_READY;
  assign w_idle        = (r_state == S_IDLE);
  // The ADS holding register stays pending until its CH2 frame handshakes, so it doubles as "being sent".
  assign w_ads_cap     = i_ADS_VALID & i_RUN & ~r_ads_pend;
  assign w_ads_drop    = i_ADS_VALID & i_RUN & r_ads_pend;
  assign w_touch_cap   = i_TOUCH_VALID & i_RUN;
  assign w_grant_ads   = w_idle & r_ads_pend & (~r_touch_pend | ~r_rr_touch);
  assign w_grant_touch = w_idle & r_touch_pend & ~w_grant_ads;

  assign w_frame_stat  = {P_HDR_STAT, 8'h00, r_ads_data[71:48]};
  assign w_frame_ch1   = {P_HDR_CH1, {8{r_ads_data[47]}}, r_ads_data[47:24]};
  assign w_frame_ch2   = {P_HDR_CH2, {8{r_ads_data[23]}}, r_ads_data[23:0]};
  assign w_frame_touch = {P_HDR_TOUCH, 20'h0, r_touch_data};

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      r_state      <= S_IDLE;
      r_ads_pend   <= 1'b0;
      r_touch_pend <= 1'b0;
      r_rr_touch   <= 1'b0;
      r_ads_data   <= '0;
      r_touch_data <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      if (w_ads_cap) begin
        r_ads_data <= i_ADS_DATA;
        r_ads_pend <= 1'b1;
      end
      if (w_ads_drop && (r_drop_cnt != {P_DROP_W{1'b1}})) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
      if (w_touch_cap) begin
        r_touch_data <= i_TOUCH_STATUS;
        r_touch_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_grant_ads) begin
            r_state    <= S_ADS_STAT;
            r_tx_data  <= w_frame_stat;
            r_tx_valid <= 1'b1;
          end else if (w_grant_touch) begin
            // Touch value is snapshotted into the TX register here, so later captures only re-arm pending.
            r_state    <= S_TOUCH;
            r_tx_data  <= w_frame_touch;
            r_tx_valid <= 1'b1;
            if (!w_touch_cap) begin
              r_touch_pend <= 1'b0;
            end
          end
        end
        S_ADS_STAT: begin
          if (w_hs) begin
            r_state   <= S_ADS_CH1;
            r_tx_data <= w_frame_ch1;
          end
        end
        S_ADS_CH1: begin
          if (w_hs) begin
            r_state   <= S_ADS_CH2;
            r_tx_data <= w_frame_ch2;
          end
        end
        S_ADS_CH2: begin
          if (w_hs) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_ads_pend <= 1'b0;
            r_rr_touch <= ~r_rr_touch;
          end
        end
        S_TOUCH: begin
          if (w_hs) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_rr_touch <= ~r_rr_touch;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_UART_DATA_TX       = r_tx_data;
  assign o_UART_DATA_TX_VALID = r_tx_valid;
  assign o_ADS_DROP_CNT       = r_drop_cnt;
  assign o_BUSY               = ~w_idle | r_ads_pend | r_touch_pend;

endmodule

// File: tb/tb_sensor_tx_scheduler.sv
// tb/tb_sensor_tx_scheduler.sv - self-checking bench for sensor_tx_scheduler
module tb_sensor_tx_scheduler;

  logic        clk = 1'b0;
  always #20 clk = ~clk;

  logic        rst, run, ads_valid, touch_valid, ready;
  logic [71:0] ads_data;
  logic [11:0] touch_st;
  logic [39:0] tx;
  logic        tx_valid, busy;
  logic [7:0]  drop;

  sensor_tx_scheduler dut (
    .i_CLK(clk), .i_RST(rst), .i_RUN(run),
    .i_ADS_DATA(ads_data), .i_ADS_VALID(ads_valid),
    .i_TOUCH_STATUS(touch_st), .i_TOUCH_VALID(touch_valid),
    .o_UART_DATA_TX(tx), .o_UART_DATA_TX_VALID(tx_valid),
    .i_UART_DATA_TX_READY(ready),
    .o_ADS_DROP_CNT(drop), .o_BUSY(busy)
  );

  int total = 0;
  int bad = 0;

  // Reference model: pending samples, a queue of frames for the packet on the bus, RR pointer.
  bit          m_ads_held, m_touch_held, m_rr_touch, m_src_ads;
  logic [71:0] m_ads;
  logic [11:0] m_touch;
  logic [39:0] m_q[$];
  int          m_drop;
  logic [39:0] hs_log[$];

  typedef struct {
    bit          ads_v;
    logic [71:0] ads_d;
    bit          touch_v;
    logic [11:0] touch_d;
    bit          exp_v;
    logic [39:0] exp_d;
    bit          exp_busy;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] sext_frame(input logic [7:0] hdr, input logic [23:0] v);
    return {hdr, {8{v[23]}}, v};
  endfunction

  task automatic model_edge();
    bit was_idle, hs, ads_busy0;
    if (rst) begin
      m_ads_held = 0; m_touch_held = 0; m_rr_touch = 0; m_src_ads = 0;
      m_ads = '0; m_touch = '0; m_q.delete(); m_drop = 0;
      return;
    end
    ads_busy0 = m_ads_held;
    was_idle  = (m_q.size() == 0);
    hs        = !was_idle && ready;
    if (was_idle && (m_ads_held || m_touch_held)) begin
      if (m_ads_held && (!m_touch_held || !m_rr_touch)) begin
        m_src_ads = 1;
        m_q.push_back({8'hE0, 8'h00, m_ads[71:48]});
        m_q.push_back(sext_frame(8'hE1, m_ads[47:24]));
        m_q.push_back(sext_frame(8'hE2, m_ads[23:0]));
      end else begin
        m_src_ads = 0;
        m_q.push_back({8'h7C, 20'h0, m_touch});
        m_touch_held = 0;
      end
    end else if (hs) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        if (m_src_ads) m_ads_held = 0;
        m_rr_touch = !m_rr_touch;
      end
    end
    if (run && ads_valid) begin
      if (ads_busy0) begin
        if (m_drop < 255) m_drop++;
      end else begin
        m_ads = ads_data;
        m_ads_held = 1;
      end
    end
    if (run && touch_valid) begin
      m_touch = touch_st;
      m_touch_held = 1;
    end
  endtask

  task automatic check_all();
    check("model_valid", {63'd0, tx_valid}, {63'd0, m_q.size() != 0});
    if (m_q.size() != 0) check("model_data", {24'd0, tx}, {24'd0, m_q[0]});
    check("model_drop", {56'd0, drop}, 64'(m_drop));
    check("model_busy", {63'd0, busy}, {63'd0, (m_q.size() != 0) || m_ads_held || m_touch_held});
  endtask

  task automatic cycle();
    if (!rst && tx_valid && ready) hs_log.push_back(tx);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cycle();
    end
    check("drain_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  initial begin
    rst = 1; run = 1; ads_valid = 0; touch_valid = 0; ready = 1;
    ads_data = '0; touch_st = '0;

    tbl[0] = '{1, 72'hC00000_7FFFFF_800001, 0, 12'h0,   0, 40'h0,           1};
    tbl[1] = '{0, 72'h0,                    0, 12'h0,   1, 40'hE0_00C00000, 1};
    tbl[2] = '{0, 72'h0,                    0, 12'h0,   1, 40'hE1_007FFFFF, 1};
    tbl[3] = '{0, 72'h0,                    0, 12'h0,   1, 40'hE2_FF800001, 1};
    tbl[4] = '{0, 72'h0,                    0, 12'h0,   0, 40'h0,           0};
    tbl[5] = '{0, 72'h0,                    1, 12'h005, 0, 40'h0,           1};
    tbl[6] = '{0, 72'h0,                    0, 12'h0,   1, 40'h7C_00000005, 1};
    tbl[7] = '{0, 72'h0,                    0, 12'h0,   0, 40'h0,           0};

    @(negedge clk);
    do_reset();
    check("reset_valid", {63'd0, tx_valid}, 64'd0);
    check("reset_data", {24'd0, tx}, 64'd0);
    check("reset_drop", {56'd0, drop}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 8; i++) begin
      ads_valid = tbl[i].ads_v; ads_data = tbl[i].ads_d;
      touch_valid = tbl[i].touch_v; touch_st = tbl[i].touch_d;
      cycle();
      ads_valid = 0; touch_valid = 0;
      check($sformatf("tbl%0d_valid", i), {63'd0, tx_valid}, {63'd0, tbl[i].exp_v});
      check($sformatf("tbl%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].exp_busy});
      if (tbl[i].exp_v) check($sformatf("tbl%0d_data", i), {24'd0, tx}, {24'd0, tbl[i].exp_d});
    end

    // Simultaneous requests: ADS first after reset; after an extra ADS packet, touch wins.
    do_reset();
    hs_log.delete();
    ads_valid = 1; ads_data = 72'h123456_000001_FFFFFE; touch_valid = 1; touch_st = 12'h3A5;
    cycle();
    ads_valid = 0; touch_valid = 0;
    drain();
    check("both_cnt", 64'(hs_log.size()), 64'd4);
    if (hs_log.size() == 4) begin
      check("both_f0", {24'd0, hs_log[0]}, {24'd0, 40'hE0_00123456});
      check("both_f2", {24'd0, hs_log[2]}, {24'd0, 40'hE2_FFFFFFFE});
      check("both_f3", {24'd0, hs_log[3]}, {24'd0, 40'h7C_000003A5});
    end
    ads_valid = 1; ads_data = 72'h000001_000002_000003;
    cycle();
    ads_valid = 0;
    drain();
    hs_log.delete();
    ads_valid = 1; ads_data = 72'h0A0B0C_0D0E0F_101112; touch_valid = 1; touch_st = 12'hFFF;
    cycle();
    ads_valid = 0; touch_valid = 0;
    drain();
    check("rr_cnt", 64'(hs_log.size()), 64'd4);
    if (hs_log.size() == 4) begin
      check("rr_f0", {24'd0, hs_log[0]}, {24'd0, 40'h7C_00000FFF});
      check("rr_f1", {24'd0, hs_log[1]}, {24'd0, 40'hE0_000A0B0C});
    end

    // Backpressure during CH1 with a touch pulse; touch must follow CH2.
    ads_valid = 1; ads_data = 72'hAAAAAA_123456_654321;
    cycle();
    ads_valid = 0;
    cycle();
    cycle();
    check("bp_ch1", {24'd0, tx}, {24'd0, 40'hE1_00123456});
    ready = 0;
    for (int i = 0; i < 10; i++) begin
      touch_valid = (i == 3); touch_st = 12'hABC;
      cycle();
      touch_valid = 0;
      check($sformatf("bp_hold%0d", i), {23'd0, tx_valid, tx}, {23'd0, 1'b1, 40'hE1_00123456});
    end
    hs_log.delete();
    ready = 1;
    drain();
    check("bp_cnt", 64'(hs_log.size()), 64'd3);
    if (hs_log.size() == 3) begin
      check("bp_f1", {24'd0, hs_log[1]}, {24'd0, 40'hE2_00654321});
      check("bp_f2", {24'd0, hs_log[2]}, {24'd0, 40'h7C_00000ABC});
    end

    // Drop counter: one packet stalled, 300 further pulses.
    ready = 0;
    ads_valid = 1; ads_data = 72'h111111_222222_333333;
    cycle();
    cycle();
    check("drop_first", {56'd0, drop}, 64'd1);
    for (int i = 0; i < 299; i++) cycle();
    ads_valid = 0;
    check("drop_sat", {56'd0, drop}, 64'hFF);
    ready = 1;
    drain();

    // RUN low blocks captures only.
    run = 0;
    ads_valid = 1; touch_valid = 1;
    cycle();
    ads_valid = 0; touch_valid = 0;
    for (int i = 0; i < 4; i++) cycle();
    check("norun_valid", {63'd0, tx_valid}, 64'd0);
    check("norun_busy", {63'd0, busy}, 64'd0);
    check("norun_drop", {56'd0, drop}, 64'hFF);
    run = 1;

    // Reset mid-packet during CH1.
    ads_valid = 1; ads_data = 72'h00000F_800000_000000;
    cycle();
    ads_valid = 0;
    cycle();
    cycle();
    check("rstmid_ch1", {24'd0, tx}, {24'd0, 40'hE1_FF800000});
    rst = 1;
    cycle();
    check("rstmid_valid", {63'd0, tx_valid}, 64'd0);
    check("rstmid_busy", {63'd0, busy}, 64'd0);
    check("rstmid_drop", {56'd0, drop}, 64'd0);
    rst = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 599) == 0);
      run         = ($urandom_range(0, 9) != 0);
      ads_valid   = ($urandom_range(0, 7) == 0);
      touch_valid = ($urandom_range(0, 9) == 0);
      ready       = ($urandom_range(0, 9) < 6);
      ads_data    = {$urandom, $urandom, $urandom};
      touch_st    = 12'($urandom);
      cycle();
    end
    rst = 0; run = 1; ads_valid = 0; touch_valid = 0; ready = 1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
